// File: rtl/pos_display_pkg.sv
// Shared constants and glyph selection for the six-digit POS total display.
package pos_display_pkg;

   localparam int unsigned H_ACTIVE    = 640;
   localparam int unsigned V_ACTIVE    = 480;
   localparam int unsigned NUM_DIGITS  = 6;
   localparam int unsigned SCALE_SHIFT = 2;
   localparam int unsigned GLYPH_W     = 8;
   localparam int unsigned GLYPH_H     = 16;

   localparam logic [3:0] GL_BLANK = 4'd10;
   localparam logic [3:0] GL_DASH  = 4'd11;

   // Leading zeros blank out; the rightmost digit always renders.
   function automatic logic [3:0] glyph_code(input logic [23:0] bcd, input logic [2:0] idx);
      logic       leading;
      logic [3:0] nib;
      glyph_code = GL_BLANK;
      leading    = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         nib = bcd[4*(NUM_DIGITS-1-i) +: 4];
         if (nib != 4'd0 || i == NUM_DIGITS - 1) leading = 1'b0;
         if (idx == 3'(i)) begin
            if (leading)         glyph_code = GL_BLANK;
            else if (nib > 4'd9) glyph_code = GL_DASH;
            else                 glyph_code = nib;
         end
      end
   endfunction

endpackage

// File: rtl/digit_font_rom.sv
// 8x16 segment-style font: numerals 0-9, blank (10), dash (11); codes 12-15 are empty.
module digit_font_rom
   import pos_display_pkg::*;
(
   input  logic [3:0] code,
   input  logic [3:0] row,
   output logic [7:0] bitmap
);

   localparam logic [7:0] HORIZ = 8'h7E;
   localparam logic [7:0] LEFT  = 8'h60;
   localparam logic [7:0] RIGHT = 8'h06;

   logic [6:0] seg; // {g,f,e,d,c,b,a}

   always_comb begin
      case (code)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         GL_DASH: seg = 7'h40;
         default: seg = 7'h00;
      endcase

      bitmap = '0;
      if (row == 4'd1)                      bitmap = seg[0] ? HORIZ : '0;
      else if (row >= 4'd2 && row <= 4'd6)  bitmap = (seg[5] ? LEFT : '0) | (seg[1] ? RIGHT : '0);
      else if (row == 4'd7 || row == 4'd8)  bitmap = seg[6] ? HORIZ : '0;
      else if (row >= 4'd9 && row <= 4'd13) bitmap = (seg[4] ? LEFT : '0) | (seg[2] ? RIGHT : '0);
      else if (row == 4'd14)                bitmap = seg[3] ? HORIZ : '0;
   end

endmodule

// File: rtl/pos_total_renderer.sv
// Overlays a six-digit BCD total on the VGA stream through a 2-stage p_tick pipeline,
// with a frame-synchronous update handshake and alert blinking.
module pos_total_renderer
   import pos_display_pkg::*;
#(
   parameter int unsigned X0     = 224,
   parameter int unsigned Y0     = 208,
   parameter logic [23:0] FG_RGB = 24'hFFFFFF,
   parameter logic [23:0] BG_RGB = 24'h000040
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p_tick,
   input  logic        video_on,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        upd_valid,
   input  logic [23:0] upd_bcd,
   output logic        upd_ready,
   input  logic        alert,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        hsync_out,
   output logic        vsync_out
);

   localparam int unsigned FIELD_W = NUM_DIGITS * (GLYPH_W << SCALE_SHIFT);
   localparam int unsigned FIELD_H = GLYPH_H << SCALE_SHIFT;
   localparam logic [9:0]  X_LO    = 10'(X0);
   localparam logic [9:0]  X_HI    = 10'(X0 + FIELD_W);
   localparam logic [9:0]  Y_LO    = 10'(Y0);
   localparam logic [9:0]  Y_HI    = 10'(Y0 + FIELD_H);
   localparam logic [9:0]  FRAME_Y = 10'(V_ACTIVE);

   logic [9:0]  dx, dy;
   logic        in_field, frame_evt, accept;
   logic [3:0]  glyph;
   logic [7:0]  font_row;
   logic [23:0] rgb;

   logic        s1_in_field_q, s1_video_q, s1_hs_q, s1_vs_q;
   logic [2:0]  s1_digit_q, s1_col_q;
   logic [3:0]  s1_row_q;
   logic        s2_in_field_q, s2_video_q, s2_hs_q, s2_vs_q, s2_blank_q;
   logic [2:0]  s2_col_q;
   logic [7:0]  s2_font_q;

   logic [23:0] pend_q, disp_q;
   logic        full_q, full_d, ready_q;
   logic [5:0]  blink_q;

   assign dx        = x - X_LO;
   assign dy        = y - Y_LO;
   assign in_field  = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
   assign frame_evt = p_tick && (x == 10'd0) && (y == FRAME_Y);
   assign accept    = upd_valid && ready_q;
   assign glyph     = glyph_code(disp_q, s1_digit_q);

   digit_font_rom u_font (
      .code   (glyph),
      .row    (s1_row_q),
      .bitmap (font_row)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_in_field_q <= 1'b0;
         s1_video_q    <= 1'b0;
         s1_hs_q       <= 1'b0;
         s1_vs_q       <= 1'b0;
         s1_digit_q    <= '0;
         s1_col_q      <= '0;
         s1_row_q      <= '0;
         s2_in_field_q <= 1'b0;
         s2_video_q    <= 1'b0;
         s2_hs_q       <= 1'b0;
         s2_vs_q       <= 1'b0;
         s2_blank_q    <= 1'b0;
         s2_col_q      <= '0;
         s2_font_q     <= '0;
      end else if (p_tick) begin
         s1_in_field_q <= in_field;
         s1_video_q    <= video_on;
         s1_hs_q       <= hsync_in;
         s1_vs_q       <= vsync_in;
         s1_digit_q    <= 3'(dx >> (SCALE_SHIFT + 3));
         s1_col_q      <= 3'(dx >> SCALE_SHIFT);
         s1_row_q      <= 4'(dy >> SCALE_SHIFT);
         s2_in_field_q <= s1_in_field_q;
         s2_video_q    <= s1_video_q;
         s2_hs_q       <= s1_hs_q;
         s2_vs_q       <= s1_vs_q;
         s2_blank_q    <= alert && blink_q[4];
         s2_col_q      <= s1_col_q;
         s2_font_q     <= font_row;
      end
   end

   // An accept needs ready=1 (pending empty), so it can never collide with an apply.
   always_comb begin
      full_d = full_q;
      if (frame_evt && full_q) full_d = 1'b0;
      if (accept)              full_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_q  <= '0;
         disp_q  <= '0;
         full_q  <= 1'b0;
         ready_q <= 1'b0;
         blink_q <= '0;
      end else begin
         if (accept)              pend_q  <= upd_bcd;
         if (frame_evt && full_q) disp_q  <= pend_q;
         if (frame_evt)           blink_q <= blink_q + 6'd1;
         full_q  <= full_d;
         ready_q <= !full_d;
      end
   end

   always_comb begin
      if (!s2_video_q)                                                  rgb = '0;
      else if (s2_font_q[3'd7 - s2_col_q] && s2_in_field_q && !s2_blank_q) rgb = FG_RGB;
      else                                                              rgb = BG_RGB;
   end

   assign red       = rgb[23:16];
   assign green     = rgb[15:8];
   assign blue      = rgb[7:0];
   assign hsync_out = s2_hs_q;
   assign vsync_out = s2_vs_q;
   assign upd_ready = ready_q;

endmodule

// File: doc/pos_total_renderer.md
POS_TOTAL_RENDERER -- requirements
Module: pos_total_renderer

Interface
REQ-001 SHALL have parameter X0, default 224, meaning the left pixel column of the digit field.
REQ-002 SHALL have parameter Y0, default 208, meaning the top pixel row of the digit field.
REQ-003 SHALL have parameter FG_RGB, default 24'hFFFFFF, meaning the glyph colour as {R,G,B}.
REQ-004 SHALL have parameter BG_RGB, default 24'h000040, meaning the background colour inside the active area.
REQ-005 SHALL have port clk, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port p_tick, input, 1 bit: the pixel-enable strobe from vgasync.
REQ-008 SHALL have port video_on, input, 1 bit: the active-area flag from vgasync.
REQ-009 SHALL have ports x and y, input, 10 bits each: the current pixel coordinates.
REQ-010 SHALL have ports hsync_in and vsync_in, input, 1 bit each: the raw syncs from vgasync.
REQ-011 SHALL have port upd_valid, input, 1 bit: a new total is offered.
REQ-012 SHALL have port upd_bcd, input, 24 bits: six BCD digits, with the most significant digit in [23:20].
REQ-013 SHALL have port upd_ready, output, 1 bit: the block can accept a new total.
REQ-014 SHALL have port alert, input, 1 bit: when high, the digits blink.
REQ-015 SHALL have ports red, green and blue, output, 8 bits each: the pixel colour.
REQ-016 SHALL have ports hsync_out and vsync_out, output, 1 bit each: the syncs delayed to align with the RGB outputs.

Function
REQ-017 Pipeline: SHALL advance only in cycles where p_tick=1, with 2 stages. RGB, hsync_out and vsync_out SHALL reflect the x/y/video_on/syncs sampled 2 p_ticks earlier.
REQ-018 Stage 1: SHALL register the in-field flag, the digit index, the glyph row, the glyph column, video_on and the syncs.
- In-field is X0 <= x < X0+192 and Y0 <= y < Y0+64.
- Digit index = (x-X0)>>5, in 0..5, with 0 as the leftmost digit.
- Glyph column = ((x-X0)>>2)&7.
- Glyph row = ((y-Y0)>>2)&15.
REQ-019 Stage 2: SHALL register the 8-bit font row from the ROM, the column and the flags. The output colour SHALL then be selected as follows:
- video_on=0 -> 0.
- Glyph pixel set, in-field and not blanked -> FG_RGB.
- Otherwise -> BG_RGB.
REQ-020 Glyph coordinates: SHALL render each glyph as 8x16 scaled by 4 (32x64 pixels). Column 0 SHALL map to font bit 7.
REQ-021 Glyph selection: SHALL render BCD 0-9 as the numerals and any nibble greater than 9 as the "-" glyph (code 11).
REQ-022 Leading-zero suppression: SHALL render zero digits to the left of the first nonzero digit as blank (code 10). Digit 5 SHALL always render, so a total of 0 shows "     0".
REQ-023 Frame event: SHALL be defined as p_tick=1 with x==0 and y==480.
REQ-024 Blink counter: SHALL be 6 bits and increment on each frame event, wrapping from 63 to 0.
REQ-025 Blink output: while alert=1 and counter bit 4 = 1, all glyph pixels SHALL be blanked, giving 16 frames on and 16 frames off.
REQ-026 Update handshake: SHALL accept a transfer when upd_valid=1 and upd_ready=1, capturing upd_bcd into a pending register.
REQ-027 upd_ready: SHALL be registered and equal to NOT pending_full.
REQ-028 Update apply: on a frame event with the pending register full, the display register SHALL load the pending value and pending_full SHALL clear. upd_ready SHALL rise the next cycle.
REQ-029 Simultaneous accept and frame event: a transfer accepted in the same cycle as a frame event SHALL NOT bypass the pending register. It SHALL be shown at the following frame event.
REQ-030 Held upd_valid: while upd_ready=0, upd_valid SHALL have no effect. upd_bcd SHALL be sampled only on an accepted transfer.
REQ-031 Mid-frame stability: the display register SHALL change only on a frame event, so no tearing occurs within a frame.

Reset
REQ-032 While reset=0 at a clock edge, SHALL clear the following:
- red, green, blue, hsync_out and vsync_out -> 0.
- All pipeline registers -> 0.
- Display register -> 0.
- Pending register -> 0, with pending_full = 0.
- Blink counter -> 0.
- upd_ready -> 0.
REQ-033 SHALL set upd_ready to 1 on the first clock edge after reset returns to 1.
REQ-034 A reset during an update SHALL discard the pending value. The display SHALL show "     0" afterwards.

Structure
REQ-035 SHALL keep the following in a shared package, pos_display_pkg:
- H_ACTIVE=640 and V_ACTIVE=480.
- NUM_DIGITS=6 and SCALE_SHIFT=2.
- GLYPH_W=8 and GLYPH_H=16.
- Glyph codes GL_BLANK=10 and GL_DASH=11.
REQ-036 SHALL use one sub-module, digit_font_rom:
- Inputs: 4-bit glyph code and 4-bit row.
- Output: 8-bit row bitmap.
- Combinational, with codes 12-15 returning 0.

Verification
REQ-037 Reset then idle frame: the field SHALL show only digit 5 as "0". upd_ready SHALL be 1 the cycle after release.
REQ-038 Load 24'h001234 mid-frame: pixels SHALL be unchanged until the next frame event. After it, the field SHALL show "  1234" and upd_ready SHALL return to 1.
REQ-039 Latency: drive x=X0+160 (digit 5, col 0), y=Y0 with p_tick=1. RGB SHALL match the expected glyph bit exactly 2 p_ticks later. With video_on=0, RGB SHALL be 0.
REQ-040 Pending full: accept 24'h000111, then hold upd_valid=1 with 24'h999999. upd_ready SHALL stay 0 and 000111 SHALL be displayed. 999999 SHALL be accepted after the frame event and displayed at the next one.
REQ-041 Invalid BCD 24'h00A005: the field SHALL show "  -005".
REQ-042 Blink: alert=1 for 64 frames. Glyph pixels SHALL be FG in frames 0-15 and 32-47 and BG in frames 16-31 and 48-63. Frame 63 SHALL wrap the counter to 0.
